// File: rtl/matvec_pkg.sv
// Shared types and width helpers for the matrix-vector sequencer.
// DW is the datapath width seen by the external MAC and result buffer.
package matvec_pkg;

  localparam int DW = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WRITE,
    DONE
  } state_e;

  // An address port is always at least one bit wide, even for a single entry.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int waw_f(input int n, input int d);
    return addr_w(n * d);
  endfunction

  function automatic int xaw_f(input int n);
    return addr_w(n);
  endfunction

  function automatic int oaw_f(input int d);
    return addr_w(d);
  endfunction

endpackage

// File: rtl/matvec_sched_valid_delay.sv
// Fixed-latency strobe delay line that keeps MAC control aligned with SRAM read data.
module valid_delay #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [LAT-1:0] sr_q, sr_d;

  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = d;
    for (int k = 1; k < LAT; k++) begin
      sr_d[k] = sr_q[k-1];
    end
  end

  // NOTE: this is a strobe pipeline, not storage, so every stage is reset;
  // a stale bit surviving reset would fire a spurious MAC enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign q = sr_q[LAT-1];

endmodule

// File: rtl/matvec_sched.sv
// Time-multiplexed matrix-vector sequencer: one weight/vector read per cycle,
// MAC strobes aligned to read data, one result write per row with backpressure.
// Optional perf counters are built when MATVEC_SCHED_PERF_EN is defined.
module matvec_sched
  import matvec_pkg::*;
#(
  parameter int N      = 128,
  parameter int D      = 128,
  parameter int RD_LAT = 1,
  parameter int WAW    = waw_f(N, D),
  parameter int XAW    = xaw_f(N),
  parameter int OAW    = oaw_f(D)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           rd_en,
  output logic [WAW-1:0] w_addr,
  output logic [XAW-1:0] x_addr,
  output logic           mac_en,
  output logic           mac_clr,
  output logic           out_wr_en,
  output logic [OAW-1:0] out_addr,
  input  logic           out_ready
`ifdef MATVEC_SCHED_PERF_EN
  ,
  output logic [31:0]    perf_cycles,
  output logic [31:0]    perf_stalls
`endif
);

  localparam int DCW = $clog2(RD_LAT + 1);
  localparam logic [XAW-1:0] J_LAST     = XAW'(N - 1);
  localparam logic [OAW-1:0] I_LAST     = OAW'(D - 1);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(RD_LAT);

  state_e         state_q, state_d;
  logic [XAW-1:0] j_q, j_d;
  logic [OAW-1:0] i_q, i_d;
  logic [WAW-1:0] w_addr_q, w_addr_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           rd_en_q, rd_en_d;
  logic           out_wr_en_q, out_wr_en_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      j_q      <= '0;
      i_q      <= '0;
      w_addr_q <= '0;
      drain_q  <= '0;
    end else begin
      // NOTE: state flops use non-blocking assignment so every register
      // samples the pre-edge value of every other register.
      state_q  <= state_d;
      j_q      <= j_d;
      i_q      <= i_d;
      w_addr_q <= w_addr_d;
      drain_q  <= drain_d;
    end
  end

  // w_addr runs as its own incrementer, so no i*N product is ever formed.
  always_comb begin
    // NOTE: hold-value defaults first, so no branch can leave a signal unassigned and infer a latch.
    state_d  = state_q;
    j_d      = j_q;
    i_d      = i_q;
    w_addr_d = w_addr_q;
    drain_d  = drain_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ISSUE;
          j_d      = '0;
          i_d      = '0;
          w_addr_d = '0;
        end
      end
      ISSUE: begin
        if (j_q == J_LAST) begin
          state_d = DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          j_d      = j_q + 1'b1;
          w_addr_d = w_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DCW'(1)) state_d = WRITE;
        else                    drain_d = drain_q - 1'b1;
      end
      WRITE: begin
        if (out_ready) begin
          if (i_q == I_LAST) begin
            state_d = DONE;
          end else begin
            state_d  = ISSUE;
            i_d      = i_q + 1'b1;
            j_d      = '0;
            w_addr_d = w_addr_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so they change
  // on the same edge as the state itself.
  always_comb begin
    busy_d      = (state_d != IDLE);
    rd_en_d     = (state_d == ISSUE);
    out_wr_en_d = (state_d == WRITE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      out_wr_en_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      rd_en_q     <= rd_en_d;
      out_wr_en_q <= out_wr_en_d;
      done_q      <= done_d;
    end
  end

  valid_delay #(.LAT(RD_LAT)) u_mac_en_dly (
    .clk (clk),
    .rst (rst),
    .d   (rd_en_q),
    .q   (mac_en)
  );

  valid_delay #(.LAT(RD_LAT)) u_mac_clr_dly (
    .clk (clk),
    .rst (rst),
    .d   (rd_en_q && (j_q == '0)),
    .q   (mac_clr)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign w_addr    = w_addr_q;
  assign x_addr    = j_q;
  assign out_wr_en = out_wr_en_q;
  assign out_addr  = i_q;

`ifdef MATVEC_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  // Counters clear on start acceptance and then hold until the next start.
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    if (state_q == IDLE) begin
      if (start) begin
        perf_cycles_d = '0;
        perf_stalls_d = '0;
      end
    end else begin
      if (perf_cycles_q != '1) perf_cycles_d = perf_cycles_q + 1'b1;
      if (state_q == WRITE && !out_ready && perf_stalls_q != '1)
        perf_stalls_d = perf_stalls_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_matvec_sched.sv
// Self-checking bench for matvec_sched: a per-pass expected trace is built from
// the row schedule and compared against two differently-sized instances every cycle.
module tb_matvec_sched;
  import matvec_pkg::*;

  localparam int NA = 4, DA = 2, LA = 1;
  localparam int NB = 3, DB = 1, LB = 2;
  localparam int WA_A = waw_f(NA, DA), XA_A = xaw_f(NA), OA_A = oaw_f(DA);
  localparam int WA_B = waw_f(NB, DB), XA_B = xaw_f(NB), OA_B = oaw_f(DB);
  localparam int TMAX = 512;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        rd_en;
    logic        mac_en;
    logic        mac_clr;
    logic        out_wr_en;
    logic [15:0] w_addr;
    logic [15:0] x_addr;
    logic [15:0] out_addr;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start_a, ready_a, busy_a, done_a, rd_en_a, mac_en_a, mac_clr_a, wr_a;
  logic [WA_A-1:0] w_addr_a;
  logic [XA_A-1:0] x_addr_a;
  logic [OA_A-1:0] out_addr_a;
  logic start_b, ready_b, busy_b, done_b, rd_en_b, mac_en_b, mac_clr_b, wr_b;
  logic [WA_B-1:0] w_addr_b;
  logic [XA_B-1:0] x_addr_b;
  logic [OA_B-1:0] out_addr_b;
`ifdef MATVEC_SCHED_PERF_EN
  logic [31:0] pc_a, ps_a, pc_b, ps_b;
`endif

  matvec_sched #(.N(NA), .D(DA), .RD_LAT(LA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_en(rd_en_a), .w_addr(w_addr_a), .x_addr(x_addr_a), .mac_en(mac_en_a),
    .mac_clr(mac_clr_a), .out_wr_en(wr_a), .out_addr(out_addr_a), .out_ready(ready_a)
`ifdef MATVEC_SCHED_PERF_EN
    , .perf_cycles(pc_a), .perf_stalls(ps_a)
`endif
  );

  matvec_sched #(.N(NB), .D(DB), .RD_LAT(LB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_en(rd_en_b), .w_addr(w_addr_b), .x_addr(x_addr_b), .mac_en(mac_en_b),
    .mac_clr(mac_clr_b), .out_wr_en(wr_b), .out_addr(out_addr_b), .out_ready(ready_b)
`ifdef MATVEC_SCHED_PERF_EN
    , .perf_cycles(pc_b), .perf_stalls(ps_b)
`endif
  );

  obs_t obs_a, obs_b, obs_cur;

  always_comb begin
    obs_a           = '0;
    obs_a.busy      = busy_a;
    obs_a.done      = done_a;
    obs_a.rd_en     = rd_en_a;
    obs_a.mac_en    = mac_en_a;
    obs_a.mac_clr   = mac_clr_a;
    obs_a.out_wr_en = wr_a;
    obs_a.w_addr    = 16'(w_addr_a);
    obs_a.x_addr    = 16'(x_addr_a);
    obs_a.out_addr  = 16'(out_addr_a);
  end

  always_comb begin
    obs_b           = '0;
    obs_b.busy      = busy_b;
    obs_b.done      = done_b;
    obs_b.rd_en     = rd_en_b;
    obs_b.mac_en    = mac_en_b;
    obs_b.mac_clr   = mac_clr_b;
    obs_b.out_wr_en = wr_b;
    obs_b.w_addr    = 16'(w_addr_b);
    obs_b.x_addr    = 16'(x_addr_b);
    obs_b.out_addr  = 16'(out_addr_b);
  end

  // Expected trace per instance, indexed by cycle number (cycle 1 follows the start edge).
  obs_t exp_t [2][TMAX];
  bit   rdy_t [2][TMAX];
  int   len_t [2];
  int   stall_t [2];
  bit   act [2];
  int   cur [2];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic cmp_obs(input string p, input obs_t a, input obs_t e);
    check({p, " busy"},      32'(a.busy),      32'(e.busy));
    check({p, " done"},      32'(a.done),      32'(e.done));
    check({p, " rd_en"},     32'(a.rd_en),     32'(e.rd_en));
    check({p, " mac_en"},    32'(a.mac_en),    32'(e.mac_en));
    check({p, " mac_clr"},   32'(a.mac_clr),   32'(e.mac_clr));
    check({p, " out_wr_en"}, 32'(a.out_wr_en), 32'(e.out_wr_en));
    if (e.rd_en) begin
      check({p, " w_addr"}, 32'(a.w_addr), 32'(e.w_addr));
      check({p, " x_addr"}, 32'(a.x_addr), 32'(e.x_addr));
    end
    if (e.out_wr_en) check({p, " out_addr"}, 32'(a.out_addr), 32'(e.out_addr));
  endtask

  // The single per-cycle compare process.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (act[k]) begin
        obs_cur = (k == 0) ? obs_a : obs_b;
        cmp_obs($sformatf("%s c%0d", (k == 0) ? "A" : "B", cur[k]), obs_cur, exp_t[k][cur[k]]);
        cur[k]++;
      end
    end
  end

  // Row schedule: N reads, RD_LAT drain cycles, write held until accepted; done after the last row.
  task automatic build(input int k, input int n, input int d, input int lat);
    int  c;
    bit  acc;
    for (int t = 0; t < TMAX; t++) exp_t[k][t] = '0;
    c          = 1;
    stall_t[k] = 0;
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < n; j++) begin
        exp_t[k][c].busy   = 1'b1;
        exp_t[k][c].rd_en  = 1'b1;
        exp_t[k][c].w_addr = 16'(i * n + j);
        exp_t[k][c].x_addr = 16'(j);
        exp_t[k][c + lat].mac_en = 1'b1;
        if (j == 0) exp_t[k][c + lat].mac_clr = 1'b1;
        c++;
      end
      for (int t = 0; t < lat; t++) begin
        exp_t[k][c].busy = 1'b1;
        c++;
      end
      acc = 1'b0;
      while (!acc) begin
        exp_t[k][c].busy      = 1'b1;
        exp_t[k][c].out_wr_en = 1'b1;
        exp_t[k][c].out_addr  = 16'(i);
        acc = rdy_t[k][c];
        if (!acc) stall_t[k]++;
        c++;
      end
    end
    exp_t[k][c].busy = 1'b1;
    exp_t[k][c].done = 1'b1;
    len_t[k] = c;
  endtask

  task automatic ready_all(input int k);
    for (int t = 0; t < TMAX; t++) rdy_t[k][t] = 1'b1;
  endtask

  task automatic ready_rand(input int k);
    for (int t = 0; t < TMAX; t++) rdy_t[k][t] = (t >= 200) ? 1'b1 : ($urandom_range(0, 2) != 0);
  endtask

  task automatic set_start(input int k, input logic v);
    if (k == 0) start_a = v; else start_b = v;
  endtask

  task automatic set_ready(input int k, input logic v);
    if (k == 0) ready_a = v; else ready_b = v;
  endtask

  task automatic check_zero(input string p, input obs_t a);
    check({p, " all-zero"}, 32'(a.busy) | 32'(a.done) | 32'(a.rd_en) | 32'(a.mac_en)
          | 32'(a.mac_clr) | 32'(a.out_wr_en), 32'd0);
    check({p, " addr-zero"}, 32'(a.w_addr) | 32'(a.x_addr) | 32'(a.out_addr), 32'd0);
  endtask

  // Runs one pass; poke pulses start during ISSUE and WRITE, abort_at>0 resets mid-pass.
  task automatic run_pass(input int k, input bit poke, input int abort_at);
    @(negedge clk);
    set_start(k, 1'b1);
    set_ready(k, rdy_t[k][1]);
    @(posedge clk);
    #1;
    set_start(k, 1'b0);
    cur[k] = 1;
    act[k] = 1'b1;
    for (int c = 1; c <= len_t[k] + 2; c++) begin
      @(negedge clk);
      set_ready(k, rdy_t[k][c]);
      set_start(k, poke && (c == 3 || c == 6));
      if (c == abort_at) begin
        #2;
        act[k] = 1'b0;
        rst    = 1'b1;
        #1;
        check_zero($sformatf("reset-mid-pass c%0d", c), (k == 0) ? obs_a : obs_b);
        @(negedge clk);
        rst = 1'b0;
        set_start(k, 1'b0);
        return;
      end
    end
    #1;
    act[k] = 1'b0;
`ifdef MATVEC_SCHED_PERF_EN
    check($sformatf("%s perf_cycles", (k == 0) ? "A" : "B"), (k == 0) ? pc_a : pc_b, 32'(len_t[k]));
    check($sformatf("%s perf_stalls", (k == 0) ? "A" : "B"), (k == 0) ? ps_a : ps_b, 32'(stall_t[k]));
`endif
  endtask

  int first_mac, mac_cnt;

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
    act[0] = 1'b0; act[1] = 1'b0; cur[0] = 0; cur[1] = 0;
    #1;
    check_zero("reset A", obs_a);
    check_zero("reset B", obs_b);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("post-reset idle A", obs_a);

    // Basic pass, with literal pins on the model's schedule.
    ready_all(0);
    build(0, NA, DA, LA);
    check("model basic done cycle", 32'(len_t[0]), 32'd13);
    check("model basic row1 first w_addr", 32'(exp_t[0][7].w_addr), 32'd4);
    check("model basic write row0 cycle", 32'(exp_t[0][6].out_wr_en), 32'd1);
    check("model basic write row1 addr", 32'(exp_t[0][12].out_addr), 32'd1);
    run_pass(0, 1'b0, 0);

    // Backpressure: out_ready low for cycles 6-8.
    ready_all(0);
    for (int t = 6; t <= 8; t++) rdy_t[0][t] = 1'b0;
    build(0, NA, DA, LA);
    check("model bp done cycle", 32'(len_t[0]), 32'd16);
    check("model bp stalls", 32'(stall_t[0]), 32'd3);
    check("model bp row1 start", 32'(exp_t[0][10].rd_en), 32'd1);
    run_pass(0, 1'b0, 0);

    // MAC alignment with two-cycle read latency.
    ready_all(1);
    build(1, NB, DB, LB);
    first_mac = -1;
    mac_cnt   = 0;
    for (int t = 0; t < 20; t++) begin
      if (exp_t[1][t].mac_en) begin
        mac_cnt++;
        if (first_mac < 0) first_mac = t;
      end
    end
    check("model B mac_en count", 32'(mac_cnt), 32'd3);
    check("model B first mac_en", 32'(first_mac), 32'd3);
    check("model B mac_clr on first", 32'(exp_t[1][3].mac_clr), 32'd1);
    check("model B mac_clr not second", 32'(exp_t[1][4].mac_clr), 32'd0);
    check("model B write after last mac", 32'(exp_t[1][6].out_wr_en), 32'd1);
    run_pass(1, 1'b0, 0);

    // Start pulses while busy must not disturb the pass.
    ready_all(0);
    build(0, NA, DA, LA);
    run_pass(0, 1'b1, 0);

    // Reset during row 1 ISSUE, then a clean full pass.
    run_pass(0, 1'b0, 8);
    @(negedge clk);
    check_zero("after reset release", obs_a);
    run_pass(0, 1'b0, 0);

    // Randomized backpressure on both instances.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 2; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        ready_rand(k);
        if (k == 0) build(0, NA, DA, LA);
        else        build(1, NB, DB, LB);
        run_pass(k, ($urandom_range(0, 1) == 1), 0);
      end
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/matvec_sched.md
Name: matvec_sched

Overview:
- Sequencer for a single-lane multiply-accumulate matrix-vector datapath computing xout[i] = sum over j of w[i*N+j]*x[j].
- Issues weight and vector memory reads, drives the external MAC's clear/enable strobes, and writes each finished row to a result buffer with backpressure.
- Replaces the fully unrolled combinational MAC array with a time-multiplexed schedule: one product per cycle.
- Sits between the top-level layer controller (start/done) and the weight/vector SRAMs, MAC unit and output buffer.

Parameters:
- N, 128, input vector length (columns per row); N >= 1.
- D, 128, output vector length (rows); D >= 1.
- RD_LAT, 1, fixed SRAM read latency in cycles; RD_LAT >= 1.
- WAW, $clog2(N*D), weight address width.
- XAW, $clog2(N), vector address width; minimum 1.
- OAW, $clog2(D), output address width; minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin one full matrix-vector pass; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the pass completes
- rd_en  out  1  read strobe to weight and vector SRAMs
- w_addr  out  WAW  weight read address
- x_addr  out  XAW  vector read address
- mac_en  out  1  MAC accumulate enable, aligned to returning read data
- mac_clr  out  1  MAC loads the product instead of accumulating (first term of a row)
- out_wr_en  out  1  result write request
- out_addr  out  OAW  result row index
- out_ready  in  1  result buffer accepts the write this cycle

Behaviour:
- Reset: FSM goes to IDLE; all outputs 0; counters i, j, w_addr cleared; read-valid delay line cleared. Reset takes effect immediately, including mid-pass; no partial write is completed.
- States: IDLE, ISSUE, DRAIN, WRITE, DONE.
- IDLE:
  - start=1 -> ISSUE with i=0, j=0, w_addr=0.
  - start is ignored in all other states.
- ISSUE:
  - rd_en=1, w_addr=i*N+j, x_addr=j.
  - w_addr is generated by a running incrementer, not a multiplier.
  - j increments each cycle. At j=N-1 -> DRAIN with drain count RD_LAT.
- Read-valid delay line: mac_en equals rd_en delayed by exactly RD_LAT cycles. mac_clr equals (rd_en && j==0) delayed by exactly RD_LAT cycles, so it is high only together with the first mac_en of each row.
- DRAIN: lasts exactly RD_LAT cycles, covering the last mac_en; then -> WRITE.
- WRITE:
  - out_wr_en=1, out_addr=i; both held stable until out_ready=1.
  - On a cycle with out_ready=1:
    - if i==D-1 -> DONE;
    - else i++, j=0 -> ISSUE (w_addr continues at (i+1)*N).
- DONE: done=1 for one cycle -> IDLE. busy falls in the same cycle the FSM enters IDLE.
- Timing with out_ready held high:
  - Each row takes N+RD_LAT+1 cycles.
  - done is asserted D*(N+RD_LAT+1)+1 cycles after the edge that samples start.
- Widths: addresses wrap never; the final w_addr is N*D-1. Counters are sized to hold N-1 and D-1 exactly.
- Outputs are registered.

Optional Feature:
- Macro: MATVEC_SCHED_PERF_EN.
- Defined:
  - Adds output perf_cycles (32 bits), counting every cycle with busy=1 during the current pass.
  - Adds output perf_stalls (32 bits), counting WRITE cycles with out_ready=0.
  - Both counters clear on the start acceptance and saturate at 0xFFFFFFFF.
  - Both are held after done until the next start; reset clears them to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package matvec_pkg holds:
  - the state enum typedef (IDLE, ISSUE, DRAIN, WRITE, DONE);
  - the data width constant DW=32 used by the MAC and buffers;
  - width helper functions for WAW/XAW/OAW.
- Sub-module valid_delay: parameterised RD_LAT-deep shift register with asynchronous reset, instantiated for mac_en and for mac_clr.

Test Plan:
- Basic pass (N=4, D=2, RD_LAT=1, out_ready=1), start at edge 0:
  - rd_en on cycles 1-4 with w_addr 0,1,2,3 and on cycles 7-10 with w_addr 4,5,6,7; x_addr 0..3 in both rows.
  - out_wr_en on cycles 6 (addr 0) and 12 (addr 1); done=1 on cycle 13.
- Backpressure: same configuration, out_ready=0 for cycles 6-8 -> out_wr_en and out_addr=0 held stable for 4 cycles; the row 1 w_addr sequence shifts by 3 cycles; done moves to cycle 16.
- MAC alignment with RD_LAT=2, N=3, D=1 -> mac_en high exactly 3 cycles, starting 2 cycles after the first rd_en; mac_clr high only on the first of those cycles; the WRITE cycle directly follows the last mac_en.
- Start while busy: start pulses during ISSUE and WRITE -> no restart; address sequence and done timing identical to the basic pass.
- Asynchronous reset asserted mid-ISSUE of row 1 -> all outputs 0 immediately; a restart then produces the full sequence from w_addr 0 with correct mac_clr and done timing.
- With MATVEC_SCHED_PERF_EN defined, backpressure scenario -> after done, perf_stalls=3 and perf_cycles=16.
